// File: rtl/ioblock_ser.sv
// Output serializer feeding the IO pad OUT/TS pins: parallel words in, LSB-first bits out.
// Optional feature macro: IOBLOCK_SER_PARITY_EN appends an even-parity bit to every frame.
module ioblock_ser #(
  parameter int WIDTH    = 8,
  parameter int TURN_CYC = 1
) (
  input  logic             IOCLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DATA,
  input  logic             VALID,
  output logic             READY,
  output logic             OUT,
  output logic             TS,
  output logic             BUSY,
  output logic             DONE
);

`ifdef IOBLOCK_SER_PARITY_EN
  localparam int F = WIDTH + 1;
`else
  localparam int F = WIDTH;
`endif
  localparam int CW = $clog2(F + 1);
  localparam logic [CW-1:0] LAST = CW'(F - 1);
  localparam logic [3:0] TURN_LAST = (TURN_CYC > 0) ? 4'(TURN_CYC - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, SHIFT, TURN} state_t;

  function automatic logic [F-1:0] make_frame(input logic [WIDTH-1:0] d);
`ifdef IOBLOCK_SER_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  state_t          state_q, state_d;
  logic [F-1:0]    sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      turn_q, turn_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic            out_q, out_d;
  logic            ts_q, ts_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic            xfer;

  assign xfer = VALID & ready_q;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    turn_d      = turn_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = SHIFT;
          sr_d    = make_frame(DATA);
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          // Frame boundary: chain the next word with no idle bit between frames.
          if (hold_full_q) begin
            sr_d        = make_frame(hold_q);
            hold_full_d = 1'b0;
          end else if (xfer) begin
            sr_d = make_frame(DATA);
          end else if (TURN_CYC == 0) begin
            state_d = IDLE;
          end else begin
            state_d = TURN;
            turn_d  = '0;
          end
        end else begin
          sr_d  = sr_q >> 1;
          cnt_d = cnt_q + CW'(1);
          if (xfer) begin
            hold_d      = DATA;
            hold_full_d = 1'b1;
          end
        end
      end
      TURN: begin
        if (turn_q == TURN_LAST) begin
          if (hold_full_q) begin
            state_d     = SHIFT;
            sr_d        = make_frame(hold_q);
            hold_full_d = 1'b0;
            cnt_d       = '0;
          end else if (xfer) begin
            // A word arriving on the closing edge goes straight to the shifter
            // so the hold register is never left full in IDLE.
            state_d = SHIFT;
            sr_d    = make_frame(DATA);
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          turn_d = turn_q + 4'd1;
          if (xfer) begin
            hold_d      = DATA;
            hold_full_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    ts_d    = (state_d == SHIFT);
    out_d   = ts_d & sr_d[0];
    done_d  = ts_d && (cnt_d == LAST);
    busy_d  = (state_d != IDLE);
    ready_d = ~hold_full_d;
  end

  always_ff @(posedge IOCLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      turn_q      <= '0;
      hold_full_q <= 1'b0;
      out_q       <= 1'b0;
      ts_q        <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      turn_q      <= turn_d;
      hold_full_q <= hold_full_d;
      out_q       <= out_d;
      ts_q        <= ts_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  // Datapath registers carry no reset; their contents are qualified by state.
  always_ff @(posedge IOCLK) begin
    sr_q   <= sr_d;
    hold_q <= hold_d;
  end

  assign READY = ready_q;
  assign OUT   = out_q;
  assign TS    = ts_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule
